// File: rtl/lms_pkg.sv
// lms_pkg: shared constants, types and helpers for the LMS weight updater.
//   NUM_TAPS   filter length (power of two, >= 4)
//   WEIGHT_W   signed coefficient width
//   MU_SHIFT   step size as an arithmetic right shift of e*x
//   LEAK_SHIFT leakage shift, only meaningful when LMS_LEAKAGE_EN is defined
//   TAP_IDX_W  width of a tap index
//   ACC_W      width of the intermediate update sum (wide enough to never wrap)
package lms_pkg;

    localparam int unsigned NUM_TAPS   = 32;
    localparam int unsigned WEIGHT_W   = 24;
    localparam int unsigned MU_SHIFT   = 20;
    localparam int unsigned LEAK_SHIFT = 12;
    localparam int unsigned TAP_IDX_W  = $clog2(NUM_TAPS);
    localparam int unsigned ACC_W      = 64;

    typedef logic signed [WEIGHT_W-1:0] weight_t;
    typedef logic signed [15:0]         sample_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_UPDATE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        UPDATE = ST_UPDATE,
        DONE   = ST_DONE
    } lms_state_t;

    // Clamp a wide signed sum into the range of a 'width'-bit signed value.
    // The result stays ACC_W wide; callers keep the low 'width' bits.
    function automatic logic signed [ACC_W-1:0] sat_weight(
        input logic signed [ACC_W-1:0] value,
        input int unsigned             width
    );
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/ref_sample_buffer.sv
// ref_sample_buffer: circular reference-sample history, DEPTH entries.
//   clk_in, rst_n_in  clock / asynchronous active-low reset (clears all entries and pointer)
//   wr_data, wr_en    write port; each strobe stores the newest sample
//   rd_offset         tap offset i: 0 addresses the newest sample x[n-0]
//   rd_data           combinational read of x[n-rd_offset]
// DEPTH must be a power of two so pointer arithmetic wraps naturally.
module ref_sample_buffer
    import lms_pkg::*;
#(
    parameter int unsigned DEPTH = lms_pkg::NUM_TAPS
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  sample_t                  wr_data,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] rd_offset,
    output sample_t                  rd_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    sample_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_addr;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
        end
    end

    // wr_ptr points at the next free slot, so the newest sample is one behind it.
    assign rd_addr = wr_ptr - rd_offset - PTR_W'(1);
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lms_weight_updater.sv
// lms_weight_updater: sign-exact LMS coefficient update, one tap per cycle.
//   clk_in, rst_n_in   clock / asynchronous active-low reset
//   sample_in/ready    reference sample stream (one-cycle strobe)
//   error_in/ready     error sample (one-cycle strobe) that triggers a pass
//   freeze_in          blocks the start of a new pass
//   weight_out, weight_idx_out, weight_valid_out   updated weight stream
//   busy_out           pass in progress (UPDATE or DONE)
//   done_out           one-cycle pulse after the last tap
//   overrun_out        one-cycle pulse when an error or pending sample is dropped
// Optional macro LMS_LEAKAGE_EN adds the leakage term w -= w >>> LEAK_SHIFT.
module lms_weight_updater
    import lms_pkg::*;
#(
    parameter int unsigned NUM_TAPS   = lms_pkg::NUM_TAPS,
    parameter int unsigned WEIGHT_W   = lms_pkg::WEIGHT_W,
    parameter int unsigned MU_SHIFT   = lms_pkg::MU_SHIFT,
    parameter int unsigned LEAK_SHIFT = lms_pkg::LEAK_SHIFT
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  sample_t                     sample_in,
    input  logic                        sample_ready,
    input  sample_t                     error_in,
    input  logic                        error_ready,
    input  logic                        freeze_in,
    output logic signed [WEIGHT_W-1:0]  weight_out,
    output logic [$clog2(NUM_TAPS)-1:0] weight_idx_out,
    output logic                        weight_valid_out,
    output logic                        busy_out,
    output logic                        done_out,
    output logic                        overrun_out
);

    localparam int unsigned      IDX_W    = $clog2(NUM_TAPS);
    localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(NUM_TAPS - 1);

`ifdef LMS_LEAKAGE_EN
    localparam bit LEAK_ON = 1'b1;
`else
    localparam bit LEAK_ON = 1'b0;
`endif

    lms_state_t                 state;
    sample_t                    err_q;
    sample_t                    x_tap;
    sample_t                    pend_data;
    logic                       pend_valid;
    sample_t                    buf_wr_data;
    logic                       buf_wr_en;
    logic [IDX_W-1:0]           tap_idx;
    logic signed [WEIGHT_W-1:0] weights [NUM_TAPS];
    logic signed [WEIGHT_W-1:0] new_weight;
    logic signed [31:0]         prod;
    logic signed [31:0]         delta;
    logic signed [ACC_W-1:0]    leak;
    logic signed [ACC_W-1:0]    sum;

    ref_sample_buffer #(
        .DEPTH (NUM_TAPS)
    ) u_ref_buf (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .wr_data   (buf_wr_data),
        .wr_en     (buf_wr_en),
        .rd_offset (tap_idx),
        .rd_data   (x_tap)
    );

    // Update datapath for the tap currently addressed by tap_idx.
    always_comb begin
        prod       = 32'(err_q) * 32'(x_tap);
        delta      = prod >>> MU_SHIFT;
        leak       = LEAK_ON ? ACC_W'(weights[tap_idx] >>> LEAK_SHIFT) : '0;
        sum        = ACC_W'(weights[tap_idx]) - leak + ACC_W'(delta);
        new_weight = WEIGHT_W'(sat_weight(sum, WEIGHT_W));
    end

    // Samples go straight into the history while idle. During a pass they wait
    // in the pending register; on the DONE->IDLE edge the pending value is
    // committed, or a sample arriving in that very cycle is committed instead.
    always_comb begin
        buf_wr_en   = 1'b0;
        buf_wr_data = sample_in;
        case (state)
            IDLE: buf_wr_en = sample_ready;
            DONE: begin
                buf_wr_en = sample_ready | pend_valid;
                if (!sample_ready) begin
                    buf_wr_data = pend_data;
                end
            end
            default: ;
        endcase
    end

    assign busy_out = (state != IDLE);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state            <= IDLE;
            err_q            <= '0;
            tap_idx          <= '0;
            pend_data        <= '0;
            pend_valid       <= 1'b0;
            weight_out       <= '0;
            weight_idx_out   <= '0;
            weight_valid_out <= 1'b0;
            done_out         <= 1'b0;
            overrun_out      <= 1'b0;
            for (int unsigned i = 0; i < NUM_TAPS; i++) begin
                weights[i] <= '0;
            end
        end else begin
            weight_valid_out <= 1'b0;
            done_out         <= 1'b0;
            overrun_out      <= 1'b0;
            case (state)
                IDLE: begin
                    if (error_ready && !freeze_in) begin
                        err_q   <= error_in;
                        tap_idx <= '0;
                        state   <= UPDATE;
                    end
                end
                UPDATE: begin
                    weights[tap_idx] <= new_weight;
                    weight_out       <= new_weight;
                    weight_idx_out   <= tap_idx;
                    weight_valid_out <= 1'b1;
                    tap_idx          <= tap_idx + IDX_W'(1);
                    if (tap_idx == LAST_TAP) begin
                        state <= DONE;
                    end
                    if (sample_ready) begin
                        pend_data  <= sample_in;
                        pend_valid <= 1'b1;
                    end
                    overrun_out <= error_ready | (sample_ready & pend_valid);
                end
                DONE: begin
                    done_out    <= 1'b1;
                    pend_valid  <= 1'b0;
                    state       <= IDLE;
                    overrun_out <= error_ready | (sample_ready & pend_valid);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lms_weight_updater.sv
// Testbench for lms_weight_updater. Two instances share the stimulus: dut_a with
// the default step size (MU_SHIFT=20) and dut_b with MU_SHIFT=0. A reference
// model keeps the sample history as a queue and the weights as plain integers.
// Honours LMS_LEAKAGE_EN in the model when the macro is defined.
`timescale 1ns/1ps
module tb_lms_weight_updater;

    localparam int     NT    = 32;
    localparam int     WW    = 24;
    localparam int     MU_A  = 20;
    localparam int     MU_B  = 0;
    localparam int     LEAK  = 12;
    localparam longint WMAX  = 64'sd8388607;
    localparam longint WMIN  = -64'sd8388608;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] sample_in = '0;
    logic               sample_ready = 1'b0;
    logic signed [15:0] error_in = '0;
    logic               error_ready = 1'b0;
    logic               freeze = 1'b0;

    logic signed [WW-1:0] wo_a, wo_b;
    logic [4:0]           idx_a, idx_b;
    logic                 vld_a, vld_b, busy_a, busy_b, done_a, done_b, ovr_a, ovr_b;

    lms_weight_updater dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .sample_in(sample_in), .sample_ready(sample_ready),
        .error_in(error_in), .error_ready(error_ready), .freeze_in(freeze),
        .weight_out(wo_a), .weight_idx_out(idx_a), .weight_valid_out(vld_a),
        .busy_out(busy_a), .done_out(done_a), .overrun_out(ovr_a)
    );

    lms_weight_updater #(.MU_SHIFT(MU_B)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .sample_in(sample_in), .sample_ready(sample_ready),
        .error_in(error_in), .error_ready(error_ready), .freeze_in(freeze),
        .weight_out(wo_b), .weight_idx_out(idx_b), .weight_valid_out(vld_b),
        .busy_out(busy_b), .done_out(done_b), .overrun_out(ovr_b)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: xq[0] is the newest sample.
    longint mw_a [NT];
    longint mw_b [NT];
    int     xq [$];

    // Observations gathered during one pass.
    logic signed [WW-1:0] obs_a [NT];
    logic signed [WW-1:0] obs_b [NT];
    int vcnt_a, vcnt_b, first_k, done_k, done_cnt, ovr_cnt, busy_cnt;
    bit idx_ok;

    function automatic longint sat(input longint v);
        if (v > WMAX) return WMAX;
        if (v < WMIN) return WMIN;
        return v;
    endfunction

    task automatic model_reset;
        for (int i = 0; i < NT; i++) begin
            mw_a[i] = 0;
            mw_b[i] = 0;
        end
        xq.delete();
        for (int i = 0; i < NT; i++) xq.push_back(0);
    endtask

    task automatic model_push(input int v);
        xq.push_front(v);
        void'(xq.pop_back());
    endtask

    task automatic model_pass(input int e);
        longint p, la, lb;
        for (int i = 0; i < NT; i++) begin
            p  = longint'(e) * longint'(xq[i]);
            la = 0;
            lb = 0;
`ifdef LMS_LEAKAGE_EN
            la = mw_a[i] >>> LEAK;
            lb = mw_b[i] >>> LEAK;
`endif
            mw_a[i] = sat(mw_a[i] - la + (p >>> MU_A));
            mw_b[i] = sat(mw_b[i] - lb + (p >>> MU_B));
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        sample_ready = 1'b0;
        error_ready = 1'b0;
        freeze = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic push_sample(input int v);
        sample_in = 16'(v);
        sample_ready = 1'b1;
        tick;
        sample_ready = 1'b0;
        model_push(v);
    endtask

    function automatic int rnd16;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Drives one pass and records what both instances produce; k counts clock
    // edges after the one that samples error_ready. Extra error strobes at
    // ek1/ek2, mid-pass samples at sk1/sk2, freeze raised at fk (-1 = none).
    task automatic do_pass(input int e, input bit sc_en, input int sc_v,
                           input int ek1, input int ek2,
                           input int sk1, input int sv1, input int sk2, input int sv2,
                           input int fk);
        int pend;
        bit pend_en;
        pend = 0;
        pend_en = 1'b0;
        for (int i = 0; i < NT; i++) begin
            obs_a[i] = 'x;
            obs_b[i] = 'x;
        end
        vcnt_a = 0; vcnt_b = 0; first_k = -1; done_k = -1;
        done_cnt = 0; ovr_cnt = 0; busy_cnt = 0; idx_ok = 1'b1;
        if (sc_en) begin
            sample_in = 16'(sc_v);
            sample_ready = 1'b1;
            model_push(sc_v);
        end
        error_in = 16'(e);
        error_ready = 1'b1;
        model_pass(e);
        tick;
        for (int k = 1; k <= 40; k++) begin
            error_ready = (k == ek1) || (k == ek2);
            sample_ready = 1'b0;
            if (k == sk1) begin sample_in = 16'(sv1); sample_ready = 1'b1; pend = sv1; pend_en = 1'b1; end
            if (k == sk2) begin sample_in = 16'(sv2); sample_ready = 1'b1; pend = sv2; pend_en = 1'b1; end
            if (k == fk) freeze = 1'b1;
            tick;
            if (vld_a) begin
                vcnt_a++;
                if (first_k < 0) first_k = k;
                if (idx_a != 5'(k - 1)) idx_ok = 1'b0;
                obs_a[idx_a] = wo_a;
            end
            if (vld_b) begin
                vcnt_b++;
                if (idx_b != 5'(k - 1)) idx_ok = 1'b0;
                obs_b[idx_b] = wo_b;
            end
            if (done_a || done_b) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (ovr_a) ovr_cnt++;
            if (busy_a) busy_cnt++;
        end
        error_ready = 1'b0;
        sample_ready = 1'b0;
        freeze = 1'b0;
        if (pend_en) model_push(pend);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        checks++; if (wo_a !== '0)  begin errors++; $display("FAIL reset_weight_out: got %0d expected 0", wo_a); end
        checks++; if (idx_a !== '0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", idx_a); end
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", vld_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_a); end
        checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", ovr_a); end
        checks++;
        if ({wo_b, idx_b, vld_b, busy_b, done_b, ovr_b} !== '0) begin
            errors++; $display("FAIL reset_dut_b: got %h expected 0", {wo_b, idx_b, vld_b, busy_b, done_b, ovr_b});
        end
        apply_reset();
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy_a); end
    endtask

    task automatic test_ramp;
        apply_reset();
        for (int v = 1; v <= NT; v++) push_sample(v);
        do_pass(1, 0, 0, -1, -1, -1, 0, -1, 0, -1);
        checks++; if (first_k != 1)   begin errors++; $display("FAIL ramp_first_valid: got %0d expected 1", first_k); end
        checks++; if (done_k != 33)   begin errors++; $display("FAIL ramp_done_cycle: got %0d expected 33", done_k); end
        checks++; if (done_cnt != 1)  begin errors++; $display("FAIL ramp_done_count: got %0d expected 1", done_cnt); end
        checks++; if (vcnt_a != NT || vcnt_b != NT) begin errors++; $display("FAIL ramp_valid_count: got %0d/%0d expected 32", vcnt_a, vcnt_b); end
        checks++; if (!idx_ok)        begin errors++; $display("FAIL ramp_idx_order: got out-of-order expected 0..31"); end
        checks++; if (busy_cnt != 32) begin errors++; $display("FAIL ramp_busy_cycles: got %0d expected 32", busy_cnt); end
        checks++; if (ovr_cnt != 0)   begin errors++; $display("FAIL ramp_overrun: got %0d expected 0", ovr_cnt); end
        for (int i = 0; i < NT; i++) begin
            checks++; if (obs_b[i] !== WW'(NT - i)) begin errors++; $display("FAIL ramp_w_b[%0d]: got %0d expected %0d", i, obs_b[i], NT - i); end
            checks++; if (obs_a[i] !== WW'(mw_a[i])) begin errors++; $display("FAIL ramp_w_a[%0d]: got %0d expected %0d", i, obs_a[i], mw_a[i]); end
        end
    endtask

    task automatic test_step_size;
        apply_reset();
        for (int v = 0; v < NT; v++) push_sample(16384);
        for (int p = 0; p < 3; p++) begin
            do_pass(16384, 0, 0, -1, -1, -1, 0, -1, 0, -1);
            for (int i = 0; i < NT; i++) begin
                checks++; if (obs_a[i] !== WW'(mw_a[i])) begin errors++; $display("FAIL step_w_a[%0d] pass %0d: got %0d expected %0d", i, p, obs_a[i], mw_a[i]); end
                checks++; if (obs_b[i] !== WW'(mw_b[i])) begin errors++; $display("FAIL step_w_b[%0d] pass %0d: got %0d expected %0d", i, p, obs_b[i], mw_b[i]); end
            end
        end
        for (int i = 0; i < NT; i++) begin
            checks++; if (obs_a[i] !== 24'sd768) begin errors++; $display("FAIL step_768[%0d]: got %0d expected 768", i, obs_a[i]); end
        end
    endtask

    task automatic test_saturation;
        apply_reset();
        for (int v = 0; v < NT; v++) push_sample(32767);
        for (int p = 0; p < 3; p++) begin
            do_pass((p < 2) ? 32767 : -32768, 0, 0, -1, -1, -1, 0, -1, 0, -1);
            for (int i = 0; i < NT; i++) begin
                checks++;
                if (obs_b[i] !== ((p < 2) ? 24'sh7FFFFF : 24'sh800000)) begin
                    errors++; $display("FAIL sat_w_b[%0d] pass %0d: got %0d expected %0d", i, p, obs_b[i], (p < 2) ? WMAX : WMIN);
                end
                checks++; if (obs_a[i] !== WW'(mw_a[i])) begin errors++; $display("FAIL sat_w_a[%0d] pass %0d: got %0d expected %0d", i, p, obs_a[i], mw_a[i]); end
            end
        end
    endtask

    task automatic test_overrun;
        int sv;
        apply_reset();
        for (int v = 0; v < NT; v++) push_sample(rnd16());
        sv = rnd16();
        do_pass(rnd16(), 0, 0, 5, 10, 7, sv, -1, 0, -1);
        checks++; if (ovr_cnt != 2)  begin errors++; $display("FAIL ovr_error_pulses: got %0d expected 2", ovr_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL ovr_done_count: got %0d expected 1", done_cnt); end
        checks++; if (vcnt_a != NT)  begin errors++; $display("FAIL ovr_valid_count: got %0d expected 32", vcnt_a); end
        do_pass(rnd16(), 0, 0, -1, -1, 7, rnd16(), 9, rnd16(), -1);
        checks++; if (ovr_cnt != 1)  begin errors++; $display("FAIL ovr_sample_replace: got %0d expected 1", ovr_cnt); end
        for (int i = 0; i < NT; i++) begin
            checks++; if (obs_b[i] !== WW'(mw_b[i])) begin errors++; $display("FAIL ovr_w_b[%0d]: got %0d expected %0d", i, obs_b[i], mw_b[i]); end
        end
        do_pass(rnd16(), 0, 0, -1, -1, -1, 0, -1, 0, -1);
        for (int i = 0; i < NT; i++) begin
            checks++; if (obs_b[i] !== WW'(mw_b[i])) begin errors++; $display("FAIL ovr_next_w_b[%0d]: got %0d expected %0d", i, obs_b[i], mw_b[i]); end
            checks++; if (obs_a[i] !== WW'(mw_a[i])) begin errors++; $display("FAIL ovr_next_w_a[%0d]: got %0d expected %0d", i, obs_a[i], mw_a[i]); end
        end
    endtask

    task automatic test_freeze;
        int act;
        act = 0;
        freeze = 1'b1;
        error_in = 16'(rnd16());
        error_ready = 1'b1;
        tick;
        error_ready = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick;
            if (vld_a || vld_b || busy_a || done_a || ovr_a) act++;
        end
        freeze = 1'b0;
        checks++; if (act != 0) begin errors++; $display("FAIL freeze_activity: got %0d active cycles expected 0", act); end
        do_pass(0, 0, 0, -1, -1, -1, 0, -1, 0, -1);
        for (int i = 0; i < NT; i++) begin
            checks++; if (obs_a[i] !== WW'(mw_a[i])) begin errors++; $display("FAIL freeze_hold_a[%0d]: got %0d expected %0d", i, obs_a[i], mw_a[i]); end
            checks++; if (obs_b[i] !== WW'(mw_b[i])) begin errors++; $display("FAIL freeze_hold_b[%0d]: got %0d expected %0d", i, obs_b[i], mw_b[i]); end
        end
        do_pass(rnd16(), 0, 0, -1, -1, -1, 0, -1, 0, 5);
        checks++; if (vcnt_a != NT || done_cnt != 1) begin errors++; $display("FAIL freeze_mid_pass: got %0d valids %0d dones expected 32 and 1", vcnt_a, done_cnt); end
        for (int i = 0; i < NT; i++) begin
            checks++; if (obs_b[i] !== WW'(mw_b[i])) begin errors++; $display("FAIL freeze_mid_w_b[%0d]: got %0d expected %0d", i, obs_b[i], mw_b[i]); end
        end
    endtask

    task automatic test_random;
        int n;
        for (int p = 0; p < 6; p++) begin
            n = int'($urandom_range(0, 3));
            for (int j = 0; j < n; j++) push_sample(rnd16());
            do_pass(rnd16(), 1'($urandom_range(0, 1)), rnd16(), -1, -1, -1, 0, -1, 0, -1);
            for (int i = 0; i < NT; i++) begin
                checks++; if (obs_a[i] !== WW'(mw_a[i])) begin errors++; $display("FAIL rand_w_a[%0d] pass %0d: got %0d expected %0d", i, p, obs_a[i], mw_a[i]); end
                checks++; if (obs_b[i] !== WW'(mw_b[i])) begin errors++; $display("FAIL rand_w_b[%0d] pass %0d: got %0d expected %0d", i, p, obs_b[i], mw_b[i]); end
            end
        end
    endtask

    task automatic test_reset_midpass;
        int dn;
        dn = 0;
        error_in = 16'(rnd16());
        error_ready = 1'b1;
        tick;
        error_ready = 1'b0;
        for (int k = 0; k < 10; k++) tick;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({wo_a, idx_a, vld_a, busy_a, done_a, ovr_a, wo_b, idx_b, vld_b, busy_b, done_b, ovr_b} !== '0) begin
            errors++; $display("FAIL midpass_reset_outputs: got %h expected 0",
                {wo_a, idx_a, vld_a, busy_a, done_a, ovr_a, wo_b, idx_b, vld_b, busy_b, done_b, ovr_b});
        end
        tick;
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 30; k++) begin
            tick;
            if (done_a || done_b || vld_a) dn++;
        end
        checks++; if (dn != 0) begin errors++; $display("FAIL midpass_no_done: got %0d active cycles expected 0", dn); end
        push_sample(rnd16());
        push_sample(rnd16());
        do_pass(rnd16(), 0, 0, -1, -1, -1, 0, -1, 0, -1);
        for (int i = 0; i < NT; i++) begin
            checks++; if (obs_a[i] !== WW'(mw_a[i])) begin errors++; $display("FAIL midpass_w_a[%0d]: got %0d expected %0d", i, obs_a[i], mw_a[i]); end
            checks++; if (obs_b[i] !== WW'(mw_b[i])) begin errors++; $display("FAIL midpass_w_b[%0d]: got %0d expected %0d", i, obs_b[i], mw_b[i]); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ramp();
        test_step_size();
        test_saturation();
        test_overrun();
        test_freeze();
        test_random();
        test_reset_midpass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
